// File: rtl/cvxif_dcache_mq_adapter.sv
// CV-X-IF memory interface to dcache adapter with an in-order retire queue
// for out-of-order load returns. Define CVXIF_MEM_MISALIGN_CHK_EN to trap misaligned accesses.
module cvxif_dcache_mq_adapter #(
    parameter int DEPTH       = 4,
    parameter int ID_WIDTH    = 4,
    parameter int INDEX_WIDTH = 12,
    parameter int TAG_WIDTH   = 20,
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   x_mem_valid_i,
    output logic                   x_mem_ready_o,
    input  logic [ID_WIDTH-1:0]    x_mem_id_i,
    input  logic [31:0]            x_mem_addr_i,
    input  logic                   x_mem_we_i,
    input  logic [3:0]             x_mem_be_i,
    input  logic [31:0]            x_mem_wdata_i,
    output logic                   x_mem_exc_o,
    output logic [5:0]             x_mem_exccode_o,
    output logic                   x_mem_result_valid_o,
    output logic [ID_WIDTH-1:0]    x_mem_result_id_o,
    output logic [31:0]            x_mem_result_rdata_o,
    output logic                   x_mem_result_err_o,
    output logic                   dc_data_req_o,
    input  logic                   dc_data_gnt_i,
    output logic [INDEX_WIDTH-1:0] dc_address_index_o,
    output logic                   dc_data_we_o,
    output logic [3:0]             dc_data_be_o,
    output logic [1:0]             dc_data_size_o,
    output logic [31:0]            dc_data_wdata_o,
    output logic [PTR_W-1:0]       dc_data_id_o,
    output logic [TAG_WIDTH-1:0]   dc_address_tag_o,
    output logic                   dc_tag_valid_o,
    input  logic                   dc_data_rvalid_i,
    input  logic [PTR_W-1:0]       dc_data_rid_i,
    input  logic [31:0]            dc_data_rdata_i
);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]     head_q, tail_q;
    logic [CNT_W-1:0]     count_q;
    logic [DEPTH-1:0]     done_q;
    logic [DEPTH-1:0]     we_q;
    logic [ID_WIDTH-1:0]  id_q    [DEPTH];
    logic [31:0]          rdata_q [DEPTH];
    logic                 tag_valid_q;
    logic [TAG_WIDTH-1:0] tag_q;

    logic             full, misaligned, accept, retire, rvalid_ok;
    logic [PTR_W-1:0] rid_rel;

    always_comb begin
        case (x_mem_be_i)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: dc_data_size_o = 2'd0;
            4'b0011, 4'b1100:                   dc_data_size_o = 2'd1;
            default:                            dc_data_size_o = 2'd2;
        endcase
    end

`ifdef CVXIF_MEM_MISALIGN_CHK_EN
    logic addr_misaligned;

    always_comb begin
        case (dc_data_size_o)
            2'd0:    addr_misaligned = 1'b0;
            2'd1:    addr_misaligned = x_mem_addr_i[0];
            default: addr_misaligned = |x_mem_addr_i[1:0];
        endcase
    end

    // Misaligned requests are answered on the spot and never reach the dcache.
    assign misaligned      = x_mem_valid_i && addr_misaligned;
    assign x_mem_exc_o     = misaligned;
    assign x_mem_exccode_o = misaligned ? (x_mem_we_i ? 6'd6 : 6'd4) : 6'd0;
`else
    assign misaligned      = 1'b0;
    assign x_mem_exc_o     = 1'b0;
    assign x_mem_exccode_o = 6'd0;
`endif

    // Full-ness comes from the registered count: a same-cycle retire frees no slot.
    assign full          = (count_q == CNT_W'(DEPTH));
    assign dc_data_req_o = x_mem_valid_i && !misaligned && !full;
    assign accept        = dc_data_req_o && dc_data_gnt_i;
    assign x_mem_ready_o = accept || misaligned;

    assign dc_address_index_o = x_mem_addr_i[INDEX_WIDTH-1:0];
    assign dc_data_we_o       = x_mem_we_i;
    assign dc_data_be_o       = x_mem_be_i;
    assign dc_data_wdata_o    = x_mem_wdata_i;
    assign dc_data_id_o       = tail_q;
    assign dc_address_tag_o   = tag_q;
    assign dc_tag_valid_o     = tag_valid_q;

    // A return counts only if its slot lies inside the occupied window and is still waiting.
    assign rid_rel   = dc_data_rid_i - head_q;
    assign rvalid_ok = dc_data_rvalid_i && ({1'b0, rid_rel} < count_q) && !done_q[dc_data_rid_i];

    assign retire               = (count_q != '0) && done_q[head_q];
    assign x_mem_result_valid_o = retire;
    assign x_mem_result_id_o    = id_q[head_q];
    assign x_mem_result_rdata_o = we_q[head_q] ? 32'd0 : rdata_q[head_q];
    assign x_mem_result_err_o   = 1'b0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            done_q      <= '0;
            tag_valid_q <= 1'b0;
            tag_q       <= '0;
        end else begin
            if (retire) begin
                done_q[head_q] <= 1'b0;
                head_q         <= head_q + 1'b1;
            end
            if (rvalid_ok) begin
                done_q[dc_data_rid_i] <= 1'b1;
            end
            if (accept) begin
                done_q[tail_q] <= x_mem_we_i;
                tail_q         <= tail_q + 1'b1;
            end
            count_q     <= count_q + CNT_W'(accept) - CNT_W'(retire);
            tag_valid_q <= accept;
            tag_q       <= accept ? x_mem_addr_i[31:INDEX_WIDTH] : '0;
        end
    end

    // NOTE: payload storage is not reset; a slot is only read after a push has written it.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            id_q[tail_q]    <= x_mem_id_i;
            we_q[tail_q]    <= x_mem_we_i;
            rdata_q[tail_q] <= 32'd0;
        end
        if (rvalid_ok) begin
            rdata_q[dc_data_rid_i] <= dc_data_rdata_i;
        end
    end

endmodule

// File: tb/tb_cvxif_dcache_mq_adapter.sv
// Self-checking bench for cvxif_dcache_mq_adapter: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cvxif_dcache_mq_adapter;
    localparam int DEPTH = 4;
    localparam int IDW   = 4;
    localparam int IW    = 12;
    localparam int TW    = 20;
    localparam int PW    = 2;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            x_mem_valid_i;
    logic            x_mem_ready_o;
    logic [IDW-1:0]  x_mem_id_i;
    logic [31:0]     x_mem_addr_i;
    logic            x_mem_we_i;
    logic [3:0]      x_mem_be_i;
    logic [31:0]     x_mem_wdata_i;
    logic            x_mem_exc_o;
    logic [5:0]      x_mem_exccode_o;
    logic            x_mem_result_valid_o;
    logic [IDW-1:0]  x_mem_result_id_o;
    logic [31:0]     x_mem_result_rdata_o;
    logic            x_mem_result_err_o;
    logic            dc_data_req_o;
    logic            dc_data_gnt_i;
    logic [IW-1:0]   dc_address_index_o;
    logic            dc_data_we_o;
    logic [3:0]      dc_data_be_o;
    logic [1:0]      dc_data_size_o;
    logic [31:0]     dc_data_wdata_o;
    logic [PW-1:0]   dc_data_id_o;
    logic [TW-1:0]   dc_address_tag_o;
    logic            dc_tag_valid_o;
    logic            dc_data_rvalid_i;
    logic [PW-1:0]   dc_data_rid_i;
    logic [31:0]     dc_data_rdata_i;

    always #5 clk_i = ~clk_i;

    cvxif_dcache_mq_adapter #(
        .DEPTH(DEPTH), .ID_WIDTH(IDW), .INDEX_WIDTH(IW), .TAG_WIDTH(TW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .x_mem_valid_i(x_mem_valid_i), .x_mem_ready_o(x_mem_ready_o),
        .x_mem_id_i(x_mem_id_i), .x_mem_addr_i(x_mem_addr_i), .x_mem_we_i(x_mem_we_i),
        .x_mem_be_i(x_mem_be_i), .x_mem_wdata_i(x_mem_wdata_i),
        .x_mem_exc_o(x_mem_exc_o), .x_mem_exccode_o(x_mem_exccode_o),
        .x_mem_result_valid_o(x_mem_result_valid_o), .x_mem_result_id_o(x_mem_result_id_o),
        .x_mem_result_rdata_o(x_mem_result_rdata_o), .x_mem_result_err_o(x_mem_result_err_o),
        .dc_data_req_o(dc_data_req_o), .dc_data_gnt_i(dc_data_gnt_i),
        .dc_address_index_o(dc_address_index_o), .dc_data_we_o(dc_data_we_o),
        .dc_data_be_o(dc_data_be_o), .dc_data_size_o(dc_data_size_o),
        .dc_data_wdata_o(dc_data_wdata_o), .dc_data_id_o(dc_data_id_o),
        .dc_address_tag_o(dc_address_tag_o), .dc_tag_valid_o(dc_tag_valid_o),
        .dc_data_rvalid_i(dc_data_rvalid_i), .dc_data_rid_i(dc_data_rid_i),
        .dc_data_rdata_i(dc_data_rdata_i)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding requests in program order, each remembering its dcache slot.
    typedef struct {
        logic [IDW-1:0] id;
        bit             we;
        bit             done;
        logic [31:0]    rdata;
        int             slot;
    } ent_t;

    ent_t        mq[$];
    int          next_slot = 0;
    bit          tag_pend  = 0;
    logic [19:0] tag_val   = '0;
    bit          e_acc, e_ret;

    function automatic int size_of(input logic [3:0] be);
        if ($countones(be) == 1) return 0;
        if (be == 4'b0011 || be == 4'b1100) return 1;
        return 2;
    endfunction

    task automatic idle();
        x_mem_valid_i    = 1'b0;
        x_mem_id_i       = '0;
        x_mem_addr_i     = '0;
        x_mem_we_i       = 1'b0;
        x_mem_be_i       = 4'b1111;
        x_mem_wdata_i    = '0;
        dc_data_gnt_i    = 1'b0;
        dc_data_rvalid_i = 1'b0;
        dc_data_rid_i    = '0;
        dc_data_rdata_i  = '0;
    endtask

    task automatic drive_req(input logic [IDW-1:0] id, input logic [31:0] addr, input bit we,
                             input logic [3:0] be, input bit gnt);
        x_mem_valid_i = 1'b1;
        x_mem_id_i    = id;
        x_mem_addr_i  = addr;
        x_mem_we_i    = we;
        x_mem_be_i    = be;
        x_mem_wdata_i = $urandom;
        dc_data_gnt_i = gnt;
    endtask

    task automatic drive_rvalid(input int rid, input logic [31:0] data);
        dc_data_rvalid_i = 1'b1;
        dc_data_rid_i    = PW'(rid);
        dc_data_rdata_i  = data;
    endtask

    // Compare every output against the model for the inputs currently applied.
    task automatic eval();
        int sz;
        bit mis, e_req;
        #1;
        sz  = size_of(x_mem_be_i);
        mis = 1'b0;
`ifdef CVXIF_MEM_MISALIGN_CHK_EN
        mis = x_mem_valid_i && ((x_mem_addr_i % (32'd1 << sz)) != 0);
`endif
        e_req = x_mem_valid_i && !mis && (mq.size() < DEPTH);
        e_acc = e_req && dc_data_gnt_i;
        e_ret = (mq.size() > 0) && mq[0].done;
        check("dc_req", dc_data_req_o, e_req);
        check("ready", x_mem_ready_o, e_acc || mis);
        check("exc", x_mem_exc_o, mis);
        check("exccode", x_mem_exccode_o, mis ? (x_mem_we_i ? 6 : 4) : 0);
        if (e_req) begin
            check("dc_index", dc_address_index_o, x_mem_addr_i % 4096);
            check("dc_we", dc_data_we_o, x_mem_we_i);
            check("dc_be", dc_data_be_o, x_mem_be_i);
            check("dc_size", dc_data_size_o, sz);
            check("dc_wdata", dc_data_wdata_o, x_mem_wdata_i);
            check("dc_id", dc_data_id_o, next_slot);
        end
        check("tag_valid", dc_tag_valid_o, tag_pend);
        check("tag", dc_address_tag_o, tag_pend ? tag_val : 0);
        check("res_valid", x_mem_result_valid_o, e_ret);
        if (e_ret) begin
            check("res_id", x_mem_result_id_o, mq[0].id);
            check("res_rdata", x_mem_result_rdata_o, mq[0].we ? 0 : mq[0].rdata);
            check("res_err", x_mem_result_err_o, 0);
        end
    endtask

    // Advance model across the rising edge, then return on the falling edge.
    task automatic tick();
        @(posedge clk_i);
        if (rst_i) begin
            mq.delete();
            next_slot = 0;
            tag_pend  = 0;
        end else begin
            if (e_ret) mq.delete(0);
            if (dc_data_rvalid_i) begin
                foreach (mq[i]) begin
                    if (mq[i].slot == int'(dc_data_rid_i) && !mq[i].done) begin
                        mq[i].done  = 1'b1;
                        mq[i].rdata = dc_data_rdata_i;
                    end
                end
            end
            if (e_acc) begin
                mq.push_back('{id: x_mem_id_i, we: x_mem_we_i, done: x_mem_we_i, rdata: 32'd0, slot: next_slot});
                next_slot = (next_slot + 1) % DEPTH;
            end
            tag_pend = e_acc;
            tag_val  = x_mem_addr_i / 4096;
        end
        @(negedge clk_i);
    endtask

    task automatic step();
        eval();
        tick();
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        eval();
        check("post_rst_res_valid", x_mem_result_valid_o, 0);
        check("post_rst_tag_valid", dc_tag_valid_o, 0);
        check("post_rst_ready", x_mem_ready_o, 0);
        check("post_rst_req", dc_data_req_o, 0);
        tick();
    endtask

    task automatic drain();
        for (int n = 0; n < 64 && mq.size() != 0; n++) begin
            int k;
            k = -1;
            idle();
            foreach (mq[i]) if (k < 0 && !mq[i].done) k = i;
            if (k >= 0) drive_rvalid(mq[k].slot, $urandom);
            step();
        end
        check("drain_empty", mq.size(), 0);
    endtask

    initial begin
        idle();
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Single load, tag one cycle later, result one cycle after rvalid.
        do_reset();
        drive_req(4'd3, 32'h0000_1004, 1'b0, 4'b1111, 1'b1);
        eval();
        check("l_ready", x_mem_ready_o, 1);
        check("l_dc_id", dc_data_id_o, 0);
        check("l_size", dc_data_size_o, 2);
        check("l_index", dc_address_index_o, 12'h004);
        tick();
        idle();
        eval();
        check("l_tag_valid", dc_tag_valid_o, 1);
        check("l_tag", dc_address_tag_o, 20'h00001);
        tick();
        drive_rvalid(0, 32'hDEAD_BEEF);
        eval();
        check("l_no_early_res", x_mem_result_valid_o, 0);
        tick();
        idle();
        eval();
        check("l_res_valid", x_mem_result_valid_o, 1);
        check("l_res_id", x_mem_result_id_o, 3);
        check("l_res_rdata", x_mem_result_rdata_o, 32'hDEAD_BEEF);
        tick();

        // Full queue blocks a fifth request until the cycle after a pop.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive_req(IDW'(i), 32'h0000_0100 * i, 1'b0, 4'b1111, 1'b1);
            step();
        end
        drive_req(4'd9, 32'h0000_3000, 1'b0, 4'b1111, 1'b1);
        eval();
        check("f_ready_full", x_mem_ready_o, 0);
        check("f_req_full", dc_data_req_o, 0);
        tick();
        drive_rvalid(0, 32'h1111_0001);
        eval();
        tick();
        dc_data_rvalid_i = 1'b0;
        eval();
        check("f_res_valid", x_mem_result_valid_o, 1);
        check("f_res_id", x_mem_result_id_o, 1);
        check("f_ready_pop_cycle", x_mem_ready_o, 0);
        tick();
        eval();
        check("f_ready_after_pop", x_mem_ready_o, 1);
        check("f_dc_id", dc_data_id_o, 0);
        tick();
        idle();
        drain();

        // Out-of-order returns still retire in request order.
        do_reset();
        drive_req(4'd5, 32'h0000_0040, 1'b0, 4'b1111, 1'b1);
        step();
        drive_req(4'd6, 32'h0000_0080, 1'b0, 4'b1111, 1'b1);
        step();
        idle();
        drive_rvalid(1, 32'h6666_6666);
        step();
        drive_rvalid(0, 32'h5555_5555);
        eval();
        check("o_no_res", x_mem_result_valid_o, 0);
        tick();
        idle();
        eval();
        check("o_res0_id", x_mem_result_id_o, 5);
        check("o_res0_rdata", x_mem_result_rdata_o, 32'h5555_5555);
        tick();
        eval();
        check("o_res1_valid", x_mem_result_valid_o, 1);
        check("o_res1_id", x_mem_result_id_o, 6);
        tick();

        // Halfword store completes one cycle after transfer with zero data.
        drive_req(4'd7, 32'h0000_2002, 1'b1, 4'b1100, 1'b1);
        eval();
        check("s_size", dc_data_size_o, 1);
        check("s_ready", x_mem_ready_o, 1);
        tick();
        idle();
        eval();
        check("s_res_valid", x_mem_result_valid_o, 1);
        check("s_res_id", x_mem_result_id_o, 7);
        check("s_res_rdata", x_mem_result_rdata_o, 0);
        tick();

        // Misaligned word load.
        drive_req(4'd2, 32'h0000_1001, 1'b0, 4'b1111, 1'b1);
        eval();
        check("m_ready", x_mem_ready_o, 1);
`ifdef CVXIF_MEM_MISALIGN_CHK_EN
        check("m_exc", x_mem_exc_o, 1);
        check("m_exccode", x_mem_exccode_o, 4);
        check("m_req", dc_data_req_o, 0);
`else
        check("m_exc", x_mem_exc_o, 0);
        check("m_req", dc_data_req_o, 1);
`endif
        tick();
        idle();
        drain();

        // Reset drops in-flight loads; late return is ignored.
        do_reset();
        drive_req(4'd1, 32'h0000_0010, 1'b0, 4'b1111, 1'b1);
        step();
        drive_req(4'd2, 32'h0000_0020, 1'b0, 4'b1111, 1'b1);
        step();
        do_reset();
        drive_rvalid(0, 32'hBAD0_0000);
        step();
        idle();
        eval();
        check("r_no_res", x_mem_result_valid_o, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive_req(IDW'(i + 8), 32'h0000_0200 * i, 1'b0, 4'b1111, 1'b1);
            eval();
            check("r_accept_empty", x_mem_ready_o, 1);
            tick();
        end
        idle();
        drain();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] be_tab [9];
            be_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111, 4'b0101, 4'b0000};
            idle();
            rst_i = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 2) != 0) begin
                logic [31:0] a;
                a = $urandom;
                if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
                drive_req(IDW'($urandom), a, 1'($urandom), be_tab[$urandom_range(0, 8)],
                          $urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 19) == 0) begin
                drive_rvalid($urandom_range(0, DEPTH - 1), $urandom);
            end else if ($urandom_range(0, 1) == 0) begin
                int pend[$];
                foreach (mq[i]) if (!mq[i].done) pend.push_back(mq[i].slot);
                if (pend.size() > 0) drive_rvalid(pend[$urandom_range(0, pend.size() - 1)], $urandom);
            end
            step();
        end
        rst_i = 1'b0;
        idle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cvxif_dcache_mq_adapter.md
CVXIF_DCACHE_MQ_ADAPTER -- requirements
Module: cvxif_dcache_mq_adapter

Interface
REQ-001 Parameter DEPTH, default 4: number of outstanding requests; power of two, range 2..16.
REQ-002 Parameter ID_WIDTH, default 4: width of the CV-X-IF instruction id.
REQ-003 Parameter INDEX_WIDTH, default 12; TAG_WIDTH, default 20; address is INDEX_WIDTH+TAG_WIDTH = 32 bits.
REQ-004 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 x_mem_valid_i  in  1; x_mem_ready_o  out  1: request handshake; transfer when both are high.
REQ-007 x_mem_id_i  in  ID_WIDTH; x_mem_addr_i  in  32; x_mem_we_i  in  1; x_mem_be_i  in  4; x_mem_wdata_i  in  32: request fields.
REQ-008 x_mem_exc_o  out  1; x_mem_exccode_o  out  6: synchronous response, valid on the transfer cycle.
REQ-009 x_mem_result_valid_o  out  1; x_mem_result_id_o  out  ID_WIDTH; x_mem_result_rdata_o  out  32; x_mem_result_err_o  out  1: result; no backpressure.
REQ-010 dc_data_req_o  out  1; dc_data_gnt_i  in  1: dcache request handshake.
REQ-011 dc_address_index_o  out  INDEX_WIDTH; dc_data_we_o  out  1; dc_data_be_o  out  4; dc_data_size_o  out  2; dc_data_wdata_o  out  32; dc_data_id_o  out  log2(DEPTH): dcache request fields.
REQ-012 dc_address_tag_o  out  TAG_WIDTH; dc_tag_valid_o  out  1: late tag.
REQ-013 dc_data_rvalid_i  in  1; dc_data_rid_i  in  log2(DEPTH); dc_data_rdata_i  in  32: load return.

Function
REQ-014 Outstanding queue: DEPTH-entry circular FIFO; entry = {id, we, done, rdata}; head/tail pointers wrap modulo DEPTH; count 0..DEPTH.
REQ-015 dc_data_req_o = x_mem_valid_i && count<DEPTH (registered count); request fields driven combinationally from x_mem inputs; dc_data_id_o = tail slot index.
REQ-016 x_mem_ready_o = dc_data_req_o && dc_data_gnt_i; on transfer, push entry at tail with done = we.
REQ-017 dc_data_size_o from be: one-hot -> 0; 0011/1100 -> 1; 1111 -> 2; any other pattern -> 2.
REQ-018 Cycle after a transfer: dc_tag_valid_o=1, dc_address_tag_o = registered addr[31:INDEX_WIDTH]; otherwise dc_tag_valid_o=0, tag 0.
REQ-019 dc_data_rvalid_i sets done and rdata of slot dc_data_rid_i; returns may be out of order.
REQ-020 Retire: when count>0 and head.done, in that cycle assert result_valid with head id, rdata (0 for stores), err=0; pop head.
REQ-021 Minimum latency: store result 1 cycle after transfer; load result 1 cycle after rvalid; results strictly in request order, at most one per cycle.
REQ-022 Push and pop in the same cycle: count unchanged; full-ness for ready uses registered count, so a retire does not enable a same-cycle accept when full.
REQ-023 x_mem_exc_o=0, exccode=0 except per REQ-027.
REQ-024 rvalid for an empty or already-done slot is ignored.

Reset
REQ-025 rst_i high at a clock edge: head, tail, count=0, all done=0, tag pipeline cleared; outputs x_mem_ready_o, result_valid, dc_data_req_o, dc_tag_valid_o low in the following cycle; in-flight requests are dropped, later returns ignored per REQ-024.

Configuration
REQ-026 Macro CVXIF_MEM_MISALIGN_CHK_EN selects misalignment checking.
REQ-027 Defined: request with addr not aligned to size of REQ-017 accepted immediately (ready=1, no dcache request, no push), exc=1, exccode 4 (load) or 6 (store). Undefined: no check; exc always 0.

Verification
REQ-028 Load addr 0x0000_1004 id 3, gnt same cycle, rvalid rid 0 rdata 0xDEADBEEF 2 cycles later -> tag 0x00001 one cycle after transfer; result id 3 rdata 0xDEADBEEF one cycle after rvalid.
REQ-029 Four loads ids 1..4 (DEPTH=4), no rvalid -> fifth request sees ready=0; rvalid rid 0 -> result id 1, fifth accepted the cycle after the pop.
REQ-030 Loads ids 5,6; rvalid rid 1 then rid 0 -> results id 5 then id 6 on consecutive cycles.
REQ-031 Store be 1100 addr 0x2002 id 7 -> dc_data_size_o=1, result id 7 rdata 0 one cycle later.
REQ-032 With CVXIF_MEM_MISALIGN_CHK_EN: load be 1111 addr 0x1001 -> ready=1, exc=1, exccode 4, dc_data_req_o=0; without it -> dcache request issued, exc=0.
REQ-033 Two loads outstanding, rst_i pulse, then rvalid rid 0 -> no result_valid; count=0.
